// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Purpose  : 8N1 UART receiver plus command-frame parser.
//            Frame = SYNC, cmd, data_hi, data_lo, xor checksum.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_rx #(
    parameter int          CLK_FREQUENCY = 50000000,
    parameter int          BAUD_RATE     = 2000000,
    parameter logic [7:0]  SYNC_BYTE     = 8'hAA,
    parameter int          TIMEOUT_BITS  = 32
) (
    input  logic        clki,
    input  logic        rst,
    input  logic        RX,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic        chk_err
);

    localparam int c_BIT_CLKS  = CLK_FREQUENCY / BAUD_RATE;
    localparam int c_CW        = $clog2(c_BIT_CLKS);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_BIT_CLKS - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_BIT_CLKS / 2 - 1);

    localparam int c_GAP_LIMIT = TIMEOUT_BITS * c_BIT_CLKS;
    localparam int c_GW        = $clog2(c_GAP_LIMIT);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(c_GAP_LIMIT - 1);

    // Receiver states
    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
    localparam logic [2:0] R_WAIT  = 3'd4;

    // Parser states
    localparam logic [2:0] P_SYNC  = 3'd0;
    localparam logic [2:0] P_CMD   = 3'd1;
    localparam logic [2:0] P_DH    = 3'd2;
    localparam logic [2:0] P_DL    = 3'd3;
    localparam logic [2:0] P_CHK   = 3'd4;

    logic            r_rx_meta;
    logic            r_rx_s;
    logic            r_rx_prev;
    logic [2:0]      r_rstate;
    logic [c_CW-1:0] r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    logic [2:0]      r_pstate;
    logic [7:0]      r_cmd;
    logic [7:0]      r_dh;
    logic [7:0]      r_dl;
    logic [c_GW-1:0] r_gap_cnt;

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    // Reset to the idle level so release never looks like a start bit.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // Byte receiver: mid-bit sampling driven by a per-bit cycle counter.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    r_bit_cnt <= '0;
                    if (r_rx_prev && !r_rx_s) begin
                        r_rstate <= R_START;
                    end
                end
                R_START: begin
                    if (r_bit_cnt == c_HALF_LAST) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        // A high line at mid start bit was only a glitch.
                        r_rstate  <= r_rx_s ? R_IDLE : R_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_rstate <= R_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_rx_s) begin
                            byte_data  <= r_shift;
                            byte_valid <= 1'b1;
                            r_rstate   <= R_IDLE;
                        end else begin
                            frame_err  <= 1'b1;
                            r_rstate   <= R_WAIT;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                R_WAIT: begin
                    // Hold off until the line returns high (break / stuck low).
                    if (r_rx_s) begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Frame parser with inter-byte timeout; a received byte always beats expiry.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_pstate  <= P_SYNC;
            r_cmd     <= '0;
            r_dh      <= '0;
            r_dl      <= '0;
            r_gap_cnt <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_data  <= '0;
            chk_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;
            if (byte_valid) begin
                r_gap_cnt <= '0;
                case (r_pstate)
                    P_SYNC: if (byte_data == SYNC_BYTE) r_pstate <= P_CMD;
                    P_CMD: begin
                        r_cmd    <= byte_data;
                        r_pstate <= P_DH;
                    end
                    P_DH: begin
                        r_dh     <= byte_data;
                        r_pstate <= P_DL;
                    end
                    P_DL: begin
                        r_dl     <= byte_data;
                        r_pstate <= P_CHK;
                    end
                    P_CHK: begin
                        if (byte_data == (r_cmd ^ r_dh ^ r_dl)) begin
                            cmd_code  <= r_cmd;
                            cmd_data  <= {r_dh, r_dl};
                            cmd_valid <= 1'b1;
                        end else begin
                            chk_err   <= 1'b1;
                        end
                        r_pstate <= P_SYNC;
                    end
                    default: r_pstate <= P_SYNC;
                endcase
            end else if (r_pstate != P_SYNC) begin
                if (frame_err || (r_gap_cnt == c_GAP_LAST)) begin
                    r_pstate  <= P_SYNC;
                    r_gap_cnt <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_rx
// Purpose  : Directed self-checking bench for uart_cmd_rx.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_rx;

    localparam int c_BIT = 25;   // 50 MHz / 2 Mbaud

    logic        clki;
    logic        rst;
    logic        RX;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_data;
    logic        frame_err;
    logic        chk_err;

    int n_checks = 0;
    int n_err    = 0;

    int cyc = 0;
    int n_bv = 0, n_cv = 0, n_fe = 0, n_ce = 0, n_long = 0;
    int last_bv_cyc = 0;
    int t_start = 0;
    logic p_bv = 1'b0, p_cv = 1'b0, p_fe = 1'b0, p_ce = 1'b0;

    int s_bv, s_cv, s_fe, s_ce;

    uart_cmd_rx #(
        .CLK_FREQUENCY(50000000),
        .BAUD_RATE    (2000000),
        .SYNC_BYTE    (8'hAA),
        .TIMEOUT_BITS (32)
    ) dut (
        .clki      (clki),
        .rst       (rst),
        .RX        (RX),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_data  (cmd_data),
        .frame_err (frame_err),
        .chk_err   (chk_err)
    );

    initial clki = 1'b0;
    always #10 clki = ~clki;

    always @(posedge clki) cyc <= cyc + 1;

    // Pulse counters and back-to-back pulse detection, sampled mid-cycle.
    always @(negedge clki) begin
        if (byte_valid) begin
            n_bv <= n_bv + 1;
            last_bv_cyc <= cyc;
        end
        if (cmd_valid) n_cv <= n_cv + 1;
        if (frame_err) n_fe <= n_fe + 1;
        if (chk_err)   n_ce <= n_ce + 1;
        if ((byte_valid && p_bv) || (cmd_valid && p_cv) ||
            (frame_err && p_fe) || (chk_err && p_ce))
            n_long <= n_long + 1;
        p_bv <= byte_valid;
        p_cv <= cmd_valid;
        p_fe <= frame_err;
        p_ce <= chk_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        @(negedge clki);
        s_bv = n_bv; s_cv = n_cv; s_fe = n_fe; s_ce = n_ce;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clki);
    endtask

    // One 8N1 character; a low stop bit leaves the line low afterwards.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clki);
        RX = 1'b0;
        t_start = cyc;
        idle(c_BIT);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            idle(c_BIT);
        end
        RX = stop;
        idle(c_BIT);
        if (stop) idle(10);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck);
        send_byte(8'hAA, 1'b1);
        send_byte(c,  1'b1);
        send_byte(dh, 1'b1);
        send_byte(dl, 1'b1);
        send_byte(ck, 1'b1);
        idle(5);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        RX  = 1'b1;
        idle(5);
        check("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("reset_outputs", {byte_data, cmd_code, cmd_data}, 32'd0);
        check("reset_pulses", {29'd0, cmd_valid, frame_err, chk_err}, 32'd0);
        rst = 1'b0;
        idle(20);

        // 1. single byte and its latency
        snap();
        send_byte(8'hA5, 1'b1);
        idle(5);
        check("t1_byte_count", n_bv - s_bv, 1);
        check("t1_byte_data", {24'd0, byte_data}, 32'hA5);
        lat = last_bv_cyc - t_start;
        check("t1_latency_237_241", {31'd0, (lat >= 237 && lat <= 241)}, 32'd1);

        // 2. good frame
        snap();
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        check("t2_cmd_count", n_cv - s_cv, 1);
        check("t2_chk_count", n_ce - s_ce, 0);
        check("t2_cmd_code", {24'd0, cmd_code}, 32'h03);
        check("t2_cmd_data", {16'd0, cmd_data}, 32'h1234);
        check("t2_byte_count", n_bv - s_bv, 5);

        // 3. bad checksum keeps previous command
        snap();
        send_frame(8'h03, 8'h12, 8'h34, 8'h00);
        check("t3_chk_count", n_ce - s_ce, 1);
        check("t3_cmd_count", n_cv - s_cv, 0);
        check("t3_cmd_hold", {8'd0, cmd_code, cmd_data}, 32'h031234);

        // 4. framing error, held-low line, then recovery
        snap();
        send_byte(8'h5A, 1'b0);
        idle(40 * c_BIT);
        check("t4_frame_err_count", n_fe - s_fe, 1);
        check("t4_no_byte_while_low", n_bv - s_bv, 0);
        RX = 1'b1;
        idle(50);
        send_frame(8'h07, 8'h00, 8'h01, 8'h06);
        check("t4_cmd_count", n_cv - s_cv, 1);
        check("t4_cmd_code", {24'd0, cmd_code}, 32'h07);
        check("t4_cmd_data", {16'd0, cmd_data}, 32'h0001);
        check("t4_single_frame_err", n_fe - s_fe, 1);

        // 5. short glitch ignored
        snap();
        @(negedge clki);
        RX = 1'b0;
        idle(5);
        RX = 1'b1;
        idle(100);
        check("t5_glitch_no_byte", n_bv - s_bv, 0);
        check("t5_glitch_no_frame_err", n_fe - s_fe, 0);
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        check("t5_cmd_count", n_cv - s_cv, 1);
        check("t5_cmd_code", {24'd0, cmd_code}, 32'h03);

        // 6a. inter-byte timeout aborts the frame
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h03, 1'b1);
        idle(40 * c_BIT);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h25, 1'b1);
        idle(5);
        check("t6_timeout_no_cmd", n_cv - s_cv, 0);
        check("t6_timeout_no_chk", n_ce - s_ce, 0);

        // 6b. reset mid-frame clears outputs, next frame parses cleanly
        send_byte(8'hAA, 1'b1);
        send_byte(8'h03, 1'b1);
        @(negedge clki);
        rst = 1'b1;
        idle(3);
        check("t6_rst_outputs", {byte_data, cmd_code, cmd_data}, 32'd0);
        check("t6_rst_pulses", {28'd0, byte_valid, cmd_valid, frame_err, chk_err}, 32'd0);
        rst = 1'b0;
        idle(20);
        snap();
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        check("t6_after_rst_cmd_count", n_cv - s_cv, 1);
        check("t6_after_rst_cmd", {8'd0, cmd_code, cmd_data}, 32'h031234);

        check("pulse_width_1cycle", n_long, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
